// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one sync FIFO write port among NUM_REQ valid/ready/last streams.
// Latency: accepted beat appears on fifo_din/fifo_wr_en one cycle later; one dead cycle per grant.
// Backpressure: fifo_full or fifo_almost_full drops the owner's ready; the grant is held until the burst ends.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 128,
  parameter int GID_WIDTH  = 2,
  parameter int MAX_BURST  = 4
) (
  input  logic                            clk,
  input  logic                            srst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]              req_last,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [DATA_WIDTH-1:0]           fifo_din,
  output logic                            fifo_wr_en,
  input  logic                            fifo_full,
  input  logic                            fifo_almost_full,
  output logic [GID_WIDTH-1:0]            grant_id,
  output logic                            busy
);

  typedef enum logic {ARB, BURST} state_t;

  state_t                 state;
  logic [GID_WIDTH-1:0]   owner;
  logic [GID_WIDTH-1:0]   last_grant;
  logic [7:0]             beat_cnt;

  logic                   stall;
  logic [GID_WIDTH-1:0]   pick;
  logic                   pick_vld;
  logic [DATA_WIDTH-1:0]  owner_data;
  logic                   owner_vld;
  logic                   owner_last;
  logic                   accept;
  logic                   burst_done;

  // almost_full guarantees a free slot for the write already registered this cycle
  assign stall = fifo_full | fifo_almost_full;
  assign busy  = (state == BURST);

  // Round-robin pick: scanning from farthest to nearest leaves the first valid after last_grant
  always_comb begin
    pick     = '0;
    pick_vld = |req_valid;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req_valid[(int'(last_grant) + k) % NUM_REQ]) begin
        pick = GID_WIDTH'((int'(last_grant) + k) % NUM_REQ);
      end
    end
  end

  // Select the current owner's stream and drive its ready while the FIFO has room
  always_comb begin
    owner_data = '0;
    owner_vld  = 1'b0;
    owner_last = 1'b0;
    req_ready  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == GID_WIDTH'(i)) begin
        owner_data   = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        owner_vld    = req_valid[i];
        owner_last   = req_last[i];
        req_ready[i] = (state == BURST) && !stall;
      end
    end
  end

  assign accept     = owner_vld && (state == BURST) && !stall;
  assign burst_done = accept && (owner_last || (int'(beat_cnt) + 1 == MAX_BURST));

  // Arbitration FSM with registered FIFO write path
  always_ff @(posedge clk) begin
    if (srst) begin
      state      <= ARB;
      owner      <= '0;
      last_grant <= GID_WIDTH'(NUM_REQ - 1);
      beat_cnt   <= '0;
      fifo_wr_en <= 1'b0;
      fifo_din   <= '0;
      grant_id   <= '0;
    end else begin
      case (state)
        ARB: begin
          fifo_wr_en <= 1'b0;
          if (pick_vld) begin
            owner    <= pick;
            grant_id <= pick;
            beat_cnt <= '0;
            state    <= BURST;
          end
        end
        BURST: begin
          fifo_wr_en <= accept;
          if (accept) begin
            fifo_din <= owner_data;
            beat_cnt <= beat_cnt + 8'd1;
          end
          if (burst_done) begin
            last_grant <= owner;
            state      <= ARB;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed scoreboard bench for fifo_wr_arbiter.
// Expected writes are queued by the stimulus; a negedge monitor pops and compares each FIFO write.
// Requester models hold a beat until it is accepted; almost_full is driven per cycle by the stimulus.
module tb_fifo_wr_arbiter;
  localparam int NR = 4;
  localparam int DW = 128;
  localparam int GW = 2;

  logic                clk = 1'b0;
  logic                srst;
  logic [NR-1:0]       req_valid;
  logic [NR*DW-1:0]    req_data;
  logic [NR-1:0]       req_last;
  logic [NR-1:0]       req_ready;
  logic [DW-1:0]       fifo_din;
  logic                fifo_wr_en;
  logic                fifo_full;
  logic                fifo_almost_full;
  logic [GW-1:0]       grant_id;
  logic                busy;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .GID_WIDTH(GW), .MAX_BURST(4)) dut (
    .clk              (clk),
    .srst             (srst),
    .req_valid        (req_valid),
    .req_data         (req_data),
    .req_last         (req_last),
    .req_ready        (req_ready),
    .fifo_din         (fifo_din),
    .fifo_wr_en       (fifo_wr_en),
    .fifo_full        (fifo_full),
    .fifo_almost_full (fifo_almost_full),
    .grant_id         (grant_id),
    .busy             (busy)
  );

  logic [DW:0]      rq [NR][$];   // per-requester beats: {last, data}
  logic [GW+DW-1:0] expq [$];     // expected writes: {gid, data}
  int               wr_cyc [$];
  int               cyc = 0;
  int               npass = 0;
  int               ntotal = 0;
  logic [NR-1:0]    acc = '0;
  logic [GW+DW-1:0] mon_e;
  int               n0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp_v);
    ntotal++;
    if (act === exp_v) npass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
  endtask

  function automatic logic [DW-1:0] mk(input int r, input int n);
    return {96'hC0DE_0000, 16'(r), 16'(n)};
  endfunction

  function automatic bit pending();
    for (int i = 0; i < NR; i++) if (rq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic enq(input int r, input int n, input bit last);
    rq[r].push_back({last, mk(r, n)});
  endtask

  task automatic expect_wr(input int r, input int n);
    expq.push_back({GW'(r), mk(r, n)});
  endtask

  // One cycle: retire beats accepted at the last edge, present the next ones, settle ready
  task automatic step(input bit af = 1'b0, input bit rst = 1'b0);
    @(negedge clk);
    for (int i = 0; i < NR; i++)
      if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
    for (int i = 0; i < NR; i++) begin
      if (rq[i].size() > 0) begin
        req_valid[i]          = 1'b1;
        req_data[i*DW +: DW]  = rq[i][0][DW-1:0];
        req_last[i]           = rq[i][0][DW];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
      end
    end
    fifo_almost_full = af;
    srst             = rst;
    #1;
    acc = req_valid & req_ready & {NR{~rst}};
  endtask

  task automatic do_reset();
    for (int i = 0; i < NR; i++) rq[i].delete();
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    wr_cyc.delete();
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((expq.size() > 0 || pending()) && n < 200) begin
      step();
      n++;
    end
    chk({name, "_drain_timeout"}, DW'(n < 200), DW'(1));
    step();
    step();
  endtask

  // Scoreboard monitor: every FIFO write must match the next expected {gid, data}
  always @(negedge clk) begin
    if (fifo_wr_en === 1'b1) begin
      wr_cyc.push_back(cyc);
      if (expq.size() == 0) begin
        chk("unexpected_write", DW'(1), DW'(0));
      end else begin
        mon_e = expq.pop_front();
        chk("wr_gid", DW'(grant_id), DW'(mon_e[GW+DW-1:DW]));
        chk("wr_data", fifo_din, mon_e[DW-1:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    srst = 1'b1;
    req_valid = '0;
    req_last = '0;
    req_data = '0;
    fifo_full = 1'b0;
    fifo_almost_full = 1'b0;

    // Reset state
    do_reset();
    chk("rst_wr_en", DW'(fifo_wr_en), DW'(0));
    chk("rst_din", fifo_din, DW'(0));
    chk("rst_ready", DW'(req_ready), DW'(0));
    chk("rst_gid", DW'(grant_id), DW'(0));
    chk("rst_busy", DW'(busy), DW'(0));

    // 1: single requester, three-beat packet, back-to-back writes
    for (int n = 0; n < 3; n++) begin
      enq(0, n, n == 2);
      expect_wr(0, n);
    end
    drain("t1");
    chk("t1_nwr", DW'(wr_cyc.size()), DW'(3));
    chk("t1_gap0", DW'(wr_cyc[1] - wr_cyc[0]), DW'(1));
    chk("t1_gap1", DW'(wr_cyc[2] - wr_cyc[1]), DW'(1));
    chk("t1_idle", DW'(busy), DW'(0));

    // 2: all requesting single-beat packets, order 0,1,2,3,0 with a dead cycle between writes
    do_reset();
    enq(0, 0, 1'b1);
    enq(0, 1, 1'b1);
    for (int r = 1; r < NR; r++) enq(r, 0, 1'b1);
    expect_wr(0, 0);
    expect_wr(1, 0);
    expect_wr(2, 0);
    expect_wr(3, 0);
    expect_wr(0, 1);
    drain("t2");
    chk("t2_nwr", DW'(wr_cyc.size()), DW'(5));
    for (int k = 1; k < 5; k++) chk("t2_gap", DW'(wr_cyc[k] - wr_cyc[k-1]), DW'(2));

    // 3: ten beats without last split into 4,4,2 by the burst limit
    do_reset();
    for (int n = 0; n < 10; n++) begin
      enq(2, n, 1'b0);
      expect_wr(2, n);
    end
    drain("t3");
    chk("t3_nwr", DW'(wr_cyc.size()), DW'(10));
    for (int k = 1; k < 10; k++)
      chk("t3_gap", DW'(wr_cyc[k] - wr_cyc[k-1]), DW'((k == 4 || k == 8) ? 2 : 1));
    chk("t3_held_busy", DW'(busy), DW'(1));
    chk("t3_held_gid", DW'(grant_id), DW'(2));

    // 4: almost_full mid-burst for five cycles
    do_reset();
    for (int n = 0; n < 4; n++) begin
      enq(1, n, n == 3);
      expect_wr(1, n);
    end
    step();
    step();
    step();
    n0 = wr_cyc.size();
    for (int s = 0; s < 5; s++) begin
      step(1'b1);
      if (s == 0) begin
        chk("t4_stall_ready", DW'(req_ready), DW'(0));
        chk("t4_stall_busy", DW'(busy), DW'(1));
        chk("t4_stall_gid", DW'(grant_id), DW'(1));
      end
    end
    chk("t4_stall_writes", DW'(wr_cyc.size() - n0), DW'(1));
    drain("t4");
    chk("t4_nwr", DW'(wr_cyc.size()), DW'(4));

    // 5: reset during the second beat; requester 0 then wins over requester 3
    do_reset();
    for (int n = 0; n < 4; n++) begin
      enq(0, n, n == 3);
      expect_wr(0, n);
    end
    expect_wr(3, 0);
    step();
    step();
    step(1'b0, 1'b1);
    enq(3, 0, 1'b1);
    step();
    chk("t5_wr_en", DW'(fifo_wr_en), DW'(0));
    chk("t5_ready", DW'(req_ready), DW'(0));
    chk("t5_busy", DW'(busy), DW'(0));
    drain("t5");

    // 6: with last_grant=1, requester 3 goes before requester 1
    do_reset();
    enq(1, 0, 1'b1);
    expect_wr(1, 0);
    drain("t6a");
    enq(1, 1, 1'b1);
    enq(3, 0, 1'b1);
    expect_wr(3, 0);
    expect_wr(1, 1);
    drain("t6b");

    chk("leftover_expected", DW'(expq.size()), DW'(0));
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
